motor_mix_scheduler: RTL and testbench

- Sequences the four receiver offset generators (throttle, pitch, roll, yaw) into one final duty value per motor, using a single time-shared adder/accumulator.
- Owns arming, failsafe timeout and output saturation.
- Sits between the offset generators and the four motor PWM generators; one mix pass per receiver frame.

---
 rtl/motor_mix_scheduler_pkg.sv | 14 +
 rtl/mix_saturate.sv | 47 ++++
 rtl/motor_mix_scheduler.sv | 164 ++++++++++++++++
 tb/tb_motor_mix_scheduler.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_mix_scheduler_pkg.sv
// rtl/motor_mix_scheduler_pkg.sv - shared states, types and packing helper for the motor mix scheduler
package motor_mix_scheduler_pkg;
   localparam int MOTOR_COUNT = 4;
   localparam int AXIS_COUNT  = 4;

   typedef enum logic [1:0] {ST_IDLE, ST_SNAP, ST_MIX, ST_UPDATE} state_e;
   typedef logic [7:0]         duty_t;
   typedef logic signed [10:0] acc_t;

   // Offset words are packed {m4,m3,m2,m1}; idx 0 selects m1.
   function automatic duty_t off_byte(input logic [31:0] word, input logic [1:0] idx);
      return word[{idx, 3'b000} +: 8];
   endfunction
endpackage

// File: rtl/mix_saturate.sv
// rtl/mix_saturate.sv - clamp a signed mix sum to the duty window, gate by armed; slew limit under MOTOR_MIX_SLEW_LIMIT_EN
module mix_saturate
   import motor_mix_scheduler_pkg::*;
#(
   parameter int MIN_DUTY = 5,
   parameter int MAX_DUTY = 100
`ifdef MOTOR_MIX_SLEW_LIMIT_EN
   , parameter int SLEW_STEP = 4
`endif
) (
   input  logic signed [10:0] sum_i,
   input  logic               armed_i,
`ifdef MOTOR_MIX_SLEW_LIMIT_EN
   input  logic [7:0]         prev_i,
`endif
   output logic [7:0]         duty_o
);
   duty_t target;

   always_comb begin
      if (sum_i < acc_t'(MIN_DUTY)) begin
         target = duty_t'(MIN_DUTY);
      end else if (sum_i > acc_t'(MAX_DUTY)) begin
         target = duty_t'(MAX_DUTY);
      end else begin
         target = duty_t'(sum_i);
      end
   end

`ifdef MOTOR_MIX_SLEW_LIMIT_EN
   // Disarm bypasses the limiter so the motors stop at once.
   always_comb begin
      duty_o = '0;
      if (armed_i) begin
         if ({1'b0, target} > ({1'b0, prev_i} + 9'(SLEW_STEP))) begin
            duty_o = prev_i + 8'(SLEW_STEP);
         end else if (({1'b0, target} + 9'(SLEW_STEP)) < {1'b0, prev_i}) begin
            duty_o = prev_i - 8'(SLEW_STEP);
         end else begin
            duty_o = target;
         end
      end
   end
`else
   assign duty_o = armed_i ? target : '0;
`endif
endmodule

// File: rtl/motor_mix_scheduler.sv
// rtl/motor_mix_scheduler.sv - time-shared four-axis motor mixer with arming, failsafe and saturation; MOTOR_MIX_SLEW_LIMIT_EN enables duty slew limiting
module motor_mix_scheduler
   import motor_mix_scheduler_pkg::*;
#(
   parameter int CENTER         = 20,
   parameter int MIN_DUTY       = 5,
   parameter int MAX_DUTY       = 100,
   parameter int ARM_THR        = 10,
   parameter int ARM_CYCLES     = 1000,
   parameter int TIMEOUT_CYCLES = 50000
`ifdef MOTOR_MIX_SLEW_LIMIT_EN
   , parameter int SLEW_STEP    = 4
`endif
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_valid,
   input  logic        arm_req,
   input  logic [31:0] thr_off,
   input  logic [31:0] pitch_off,
   input  logic [31:0] roll_off,
   input  logic [31:0] yaw_off,
   output logic [31:0] duty,
   output logic        duty_valid,
   output logic        armed,
   output logic        failsafe,
   output logic        busy
);
   localparam int   ARM_W = $clog2(ARM_CYCLES + 1);
   localparam int   TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam acc_t BIAS  = acc_t'(3 * CENTER);

   state_e                        state_q, state_d;
   logic [3:0]                    step_q, step_d;
   logic                          pending_q, pending_d;
   logic [AXIS_COUNT-1:0][31:0]   snap_q;
   acc_t                          acc_q, acc_d;
   acc_t                          res_q [MOTOR_COUNT];
   acc_t                          res_d [MOTOR_COUNT];
   logic [MOTOR_COUNT-1:0][7:0]   duty_q, sat_duty;
   logic [ARM_W-1:0]              arm_cnt_q;
   logic [TO_W-1:0]               to_cnt_q;
   logic                          armed_q, failsafe_q;
   logic [1:0]                    motor, term;
   acc_t                          term_val;
   logic                          last_mix, timeout_hit, arm_qual;

   assign motor       = step_q[3:2];
   assign term        = step_q[1:0];
   assign term_val    = acc_t'({3'b000, off_byte(snap_q[term], motor)});
   assign last_mix    = (state_q == ST_MIX) && (step_q == 4'hF);
   assign timeout_hit = !frame_valid && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
   assign arm_qual    = arm_req && !armed_q && (snap_q[0][7:0] <= 8'(ARM_THR));

   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      pending_d = pending_q;
      if (frame_valid && (state_q != ST_IDLE)) pending_d = 1'b1;
      case (state_q)
         ST_IDLE: if (frame_valid) state_d = ST_SNAP;
         ST_SNAP: begin
            state_d = ST_MIX;
            step_d  = '0;
         end
         ST_MIX: begin
            step_d = step_q + 4'd1;
            if (step_q == 4'hF) state_d = ST_UPDATE;
         end
         default: begin
            // A frame arriving in this very cycle is folded into the pending request.
            if (pending_q || frame_valid) begin
               state_d   = ST_SNAP;
               pending_d = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   always_comb begin
      acc_d = acc_q;
      for (int i = 0; i < MOTOR_COUNT; i++) res_d[i] = res_q[i];
      if (state_q == ST_MIX) begin
         acc_d = (term == 2'd0) ? (term_val - BIAS) : (acc_q + term_val);
         if (term == 2'd3) res_d[motor] = acc_d;
      end
   end

   for (genvar g = 0; g < MOTOR_COUNT; g++) begin : g_sat
      mix_saturate #(
         .MIN_DUTY (MIN_DUTY),
         .MAX_DUTY (MAX_DUTY)
`ifdef MOTOR_MIX_SLEW_LIMIT_EN
         , .SLEW_STEP(SLEW_STEP)
`endif
      ) u_sat (
         .sum_i   (res_d[g]),
         .armed_i (armed_q),
`ifdef MOTOR_MIX_SLEW_LIMIT_EN
         .prev_i  (duty_q[g]),
`endif
         .duty_o  (sat_duty[g])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         step_q     <= '0;
         pending_q  <= 1'b0;
         snap_q     <= '0;
         acc_q      <= '0;
         for (int i = 0; i < MOTOR_COUNT; i++) res_q[i] <= '0;
         duty_q     <= '0;
         arm_cnt_q  <= '0;
         to_cnt_q   <= '0;
         armed_q    <= 1'b0;
         failsafe_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         pending_q <= pending_d;
         acc_q     <= acc_d;
         for (int i = 0; i < MOTOR_COUNT; i++) res_q[i] <= res_d[i];
         if (state_q == ST_SNAP) snap_q <= {yaw_off, roll_off, pitch_off, thr_off};
         if (last_mix) duty_q <= sat_duty;

         if (frame_valid) begin
            to_cnt_q <= '0;
         end else if (to_cnt_q != TO_W'(TIMEOUT_CYCLES)) begin
            to_cnt_q <= to_cnt_q + 1'b1;
         end

         if (arm_qual) begin
            if (arm_cnt_q == ARM_W'(ARM_CYCLES - 1)) begin
               arm_cnt_q <= '0;
               armed_q   <= 1'b1;
            end else begin
               arm_cnt_q <= arm_cnt_q + 1'b1;
            end
         end else begin
            arm_cnt_q <= '0;
         end
         if (!arm_req) armed_q <= 1'b0;
         if (frame_valid) failsafe_q <= 1'b0;

         // Timeout overrides any arming or duty load in the same cycle.
         if (timeout_hit) begin
            failsafe_q <= 1'b1;
            armed_q    <= 1'b0;
            arm_cnt_q  <= '0;
            duty_q     <= '0;
         end
      end
   end

   assign duty       = duty_q;
   assign duty_valid = (state_q == ST_UPDATE);
   assign busy       = (state_q != ST_IDLE);
   assign armed      = armed_q;
   assign failsafe   = failsafe_q;
endmodule

// File: tb/tb_motor_mix_scheduler.sv
// tb/tb_motor_mix_scheduler.sv - randomized self-checking bench for motor_mix_scheduler
module tb_motor_mix_scheduler;
   localparam int CENTER   = 20;
   localparam int MIN_DUTY = 5;
   localparam int MAX_DUTY = 100;
`ifdef MOTOR_MIX_SLEW_LIMIT_EN
   localparam int SLEW_STEP = 4;
`endif

   logic        clk = 1'b0;
   logic        rst_n, frame_valid, arm_req;
   logic [31:0] thr_off, pitch_off, roll_off, yaw_off;
   logic [31:0] duty;
   logic        duty_valid, armed, failsafe, busy;

   int          checks = 0;
   int          errors = 0;
   bit          exp_armed;
   logic [31:0] prev_duty;

   always #5 clk = ~clk;

   motor_mix_scheduler dut (
      .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .arm_req(arm_req),
      .thr_off(thr_off), .pitch_off(pitch_off), .roll_off(roll_off), .yaw_off(yaw_off),
      .duty(duty), .duty_valid(duty_valid), .armed(armed), .failsafe(failsafe), .busy(busy)
   );

   function automatic logic [31:0] model(input logic [31:0] t, p, r, y, input bit arm);
      logic [31:0] res = '0;
      for (int m = 0; m < 4; m++) begin
         int s, c;
         s = int'(t[m*8 +: 8]) + int'(p[m*8 +: 8]) + int'(r[m*8 +: 8]) + int'(y[m*8 +: 8]) - 3 * CENTER;
         c = (s < MIN_DUTY) ? MIN_DUTY : ((s > MAX_DUTY) ? MAX_DUTY : s);
         if (!arm) c = 0;
`ifdef MOTOR_MIX_SLEW_LIMIT_EN
         else begin
            int pv;
            pv = int'(prev_duty[m*8 +: 8]);
            if (c > pv + SLEW_STEP) c = pv + SLEW_STEP;
            else if (c < pv - SLEW_STEP) c = pv - SLEW_STEP;
         end
`endif
         res[m*8 +: 8] = 8'(c);
      end
      return res;
   endfunction

   function automatic logic [31:0] rnd_word();
      logic [31:0] w;
      for (int b = 0; b < 4; b++)
         w[b*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 50));
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input logic [31:0] t, p, r, y, input string name);
      logic [31:0] exp_d;
      int n;
      exp_d = model(t, p, r, y, exp_armed);
      thr_off = t; pitch_off = p; roll_off = r; yaw_off = y;
      frame_valid = 1'b1;
      tick();
      frame_valid = 1'b0;
      n = 1;
      while (duty_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (n !== 18) begin
         errors++;
         $display("FAIL %s latency: got %0d cycles, expected 18", name, n);
      end
      checks++;
      if (duty !== exp_d) begin
         errors++;
         $display("FAIL %s duty: got %h, expected %h", name, duty, exp_d);
      end
      prev_duty = exp_d;
      tick();
      checks++;
      if (duty_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s pulse width: duty_valid=%b, expected 0", name, duty_valid);
      end
   endtask

   task automatic arm_up(input string name);
      int n;
      arm_req = 1'b0;
      tick();
      exp_armed = 1'b0;
      run_frame(32'h0a0b0908, 32'h14141414, 32'h14141414, 32'h14141414, {name, "_prearm"});
      arm_req = 1'b1;
      n = 0;
      while (armed !== 1'b1 && n < 1100) begin
         tick();
         n++;
      end
      checks++;
      if (n !== 1000) begin
         errors++;
         $display("FAIL %s arm cycles: armed after %0d cycles, expected 1000", name, n);
      end
      exp_armed = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; frame_valid = 1'b0; arm_req = 1'b0;
      thr_off = '0; pitch_off = '0; roll_off = '0; yaw_off = '0;
      repeat (3) tick();
      checks++;
      if (duty !== 32'h0) begin errors++; $display("FAIL reset duty: got %h, expected 0", duty); end
      checks++;
      if (duty_valid !== 1'b0) begin errors++; $display("FAIL reset duty_valid: got %b, expected 0", duty_valid); end
      checks++;
      if (armed !== 1'b0) begin errors++; $display("FAIL reset armed: got %b, expected 0", armed); end
      checks++;
      if (failsafe !== 1'b0) begin errors++; $display("FAIL reset failsafe: got %b, expected 0", failsafe); end
      rst_n = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b, expected 0", busy); end
      exp_armed = 1'b0;
      prev_duty = '0;
   endtask

   task automatic test_arming();
      int seen;
      arm_up("arm_thr8");
      arm_req = 1'b0;
      tick();
      checks++;
      if (armed !== 1'b0) begin errors++; $display("FAIL disarm: armed=%b, expected 0", armed); end
      exp_armed = 1'b0;
      run_frame(32'h0c0c0c0c, 32'h14141414, 32'h14141414, 32'h14141414, "arm_thr12_frame");
      arm_req = 1'b1;
      seen = 0;
      repeat (1100) begin
         tick();
         if (armed === 1'b1) seen++;
      end
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL arm_thr12: armed for %0d cycles, expected 0", seen); end
      arm_req = 1'b0;
      tick();
   endtask

   task automatic test_mix();
      arm_up("mix_arm");
      run_frame(32'h1e1e1e1e, 32'h14141414, 32'h14141414, 32'h14141414, "mix_30");
      run_frame({rnd_word()} & 32'hffffff00 | 32'hff, 32'h000000ff | (rnd_word() & 32'hffffff00),
                32'h000000ff, 32'h000000ff, "mix_max");
      run_frame(32'h0, 32'h0, 32'h0, 32'h0, "mix_min");
      for (int i = 0; i < 16; i++)
         run_frame(rnd_word(), rnd_word(), rnd_word(), rnd_word(), $sformatf("mix_rand%0d", i));
      arm_req = 1'b0;
      tick();
      exp_armed = 1'b0;
      run_frame(rnd_word(), rnd_word(), rnd_word(), rnd_word(), "mix_disarmed");
   endtask

   task automatic b2b_run(input int p2, input int p3, input string name);
      logic [31:0] a_t, a_p, e_t, e_p, exp_a, exp_e;
      int cyc[$];
      logic [31:0] dv[$];
      a_t = rnd_word(); a_p = rnd_word(); e_t = rnd_word(); e_p = rnd_word();
      exp_a = model(a_t, a_p, 32'h14141414, 32'h14141414, exp_armed);
      prev_duty = exp_a;
      exp_e = model(e_t, e_p, 32'h14141414, 32'h14141414, exp_armed);
      prev_duty = exp_e;
      roll_off = 32'h14141414; yaw_off = 32'h14141414;
      for (int c = 0; c < 60; c++) begin
         frame_valid = (c == 0) || (c == p2) || (c == p3);
         if (c <= 1) begin thr_off = a_t; pitch_off = a_p; end
         else if (c < 6) begin thr_off = rnd_word(); pitch_off = rnd_word(); end
         else begin thr_off = e_t; pitch_off = e_p; end
         if (duty_valid === 1'b1) begin cyc.push_back(c); dv.push_back(duty); end
         tick();
      end
      frame_valid = 1'b0;
      checks++;
      if (cyc.size() !== 2) begin
         errors++;
         $display("FAIL %s pulse count: got %0d, expected 2", name, cyc.size());
      end else begin
         checks++;
         if (cyc[0] !== 18 || cyc[1] !== 36) begin
            errors++;
            $display("FAIL %s pulse cycles: got %0d,%0d, expected 18,36", name, cyc[0], cyc[1]);
         end
         checks++;
         if (dv[0] !== exp_a) begin errors++; $display("FAIL %s first duty: got %h, expected %h", name, dv[0], exp_a); end
         checks++;
         if (dv[1] !== exp_e) begin errors++; $display("FAIL %s second duty: got %h, expected %h", name, dv[1], exp_e); end
      end
   endtask

   task automatic test_back_to_back();
      arm_up("b2b_arm");
      b2b_run(5, 8, "b2b_overlap");
      b2b_run(18, 18, "b2b_update_cycle");
   endtask

   task automatic test_reset_mid_mix();
      int dv = 0;
      run_frame(32'h3c3c3c3c, 32'h14141414, 32'h14141414, 32'h14141414, "pre_reset");
      frame_valid = 1'b1;
      tick();
      frame_valid = 1'b0;
      repeat (8) tick();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL mid_mix busy: got %b, expected 1", busy); end
      rst_n = 1'b0;
      #2;
      checks++;
      if (duty !== 32'h0) begin errors++; $display("FAIL async reset duty: got %h, expected 0", duty); end
      checks++;
      if (armed !== 1'b0 || busy !== 1'b0 || duty_valid !== 1'b0 || failsafe !== 1'b0) begin
         errors++;
         $display("FAIL async reset flags: armed=%b busy=%b dv=%b fs=%b, expected all 0", armed, busy, duty_valid, failsafe);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_armed = 1'b0;
      prev_duty = '0;
      repeat (40) begin
         tick();
         if (duty_valid === 1'b1) dv++;
      end
      checks++;
      if (dv !== 0) begin errors++; $display("FAIL post reset duty_valid: got %0d pulses, expected 0", dv); end
   endtask

   task automatic test_failsafe();
      int dv = 0;
      int n;
      arm_up("fs_arm");
      thr_off = 32'h28282828; pitch_off = 32'h14141414; roll_off = 32'h14141414; yaw_off = 32'h14141414;
      frame_valid = 1'b1;
      tick();
      frame_valid = 1'b0;
      for (int k = 1; k <= 50000; k++) begin
         tick();
         if (k >= 20 && duty_valid === 1'b1) dv++;
         if (k == 49999) begin
            checks++;
            if (failsafe !== 1'b0 || armed !== 1'b1) begin
               errors++;
               $display("FAIL before timeout: failsafe=%b armed=%b, expected 0,1", failsafe, armed);
            end
         end
      end
      checks++;
      if (failsafe !== 1'b1 || armed !== 1'b0) begin
         errors++;
         $display("FAIL at timeout: failsafe=%b armed=%b, expected 1,0", failsafe, armed);
      end
      checks++;
      if (duty !== 32'h0) begin errors++; $display("FAIL timeout duty: got %h, expected 0", duty); end
      checks++;
      if (dv !== 0) begin errors++; $display("FAIL timeout duty_valid: got %0d pulses, expected 0", dv); end
      exp_armed = 1'b0;
      prev_duty = '0;
      run_frame(32'h08080808, 32'h14141414, 32'h14141414, 32'h14141414, "fs_clear");
      checks++;
      if (failsafe !== 1'b0) begin errors++; $display("FAIL failsafe clear: got %b, expected 0", failsafe); end
      repeat (900) tick();
      checks++;
      if (armed !== 1'b0) begin errors++; $display("FAIL early rearm: armed=%b, expected 0", armed); end
      n = 0;
      while (armed !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (armed !== 1'b1) begin errors++; $display("FAIL rearm: armed=%b, expected 1", armed); end
   endtask

   initial begin
      test_reset();
      test_arming();
      test_mix();
      test_back_to_back();
      test_reset_mid_mix();
      test_failsafe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
